// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares the DDR2 controller request path (address FIFO + write-data FIFO)
//   among N_PORTS requesters. Port 0 (pixel feeder) has fixed top priority,
//   ports 1..N_PORTS-1 are served round-robin. Outstanding read bursts are
//   tracked in an in-order tag FIFO so returning read beats reach their owner.
//
// Ports
//   clk, rst_n            clock (cpu_clk_g domain), async active-low reset
//   req_valid/req_rnw     per-port request pending / 1 = read burst
//   req_addr              packed per-port burst addresses
//   req_wdata/req_wmask   packed per-port two-beat write bursts (beat 0 low)
//   req_ready             one-cycle pulse when a port's command is pushed
//   af_addr/af_cmd/af_wr_en, af_full      MIG address FIFO
//   wdf_data/wdf_mask/wdf_wr_en, wdf_full MIG write-data FIFO
//   rd_data_valid         MIG read beat valid
//   rd_valid              read beat valid steered to the owning port
//   rd_err                sticky: read beat arrived with no outstanding tag
//
// Optional feature
//   ARB_STARVE_GUARD_EN   after STARVE_LIMIT consecutive port-0 grants made
//                         while other ports wait, one grant goes to them.
`timescale 1ns/1ps
module mem_req_arbiter #(
   parameter int N_PORTS      = 4,
   parameter int ADDR_W       = 31,
   parameter int DATA_W       = 128,
   parameter int MASK_W       = 16,
   parameter int TAG_DEPTH    = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_PORTS-1:0]            req_valid,
   input  logic [N_PORTS-1:0]            req_rnw,
   input  logic [N_PORTS*ADDR_W-1:0]     req_addr,
   input  logic [N_PORTS*2*DATA_W-1:0]   req_wdata,
   input  logic [N_PORTS*2*MASK_W-1:0]   req_wmask,
   output logic [N_PORTS-1:0]            req_ready,
   output logic [ADDR_W-1:0]             af_addr,
   output logic [2:0]                    af_cmd,
   output logic                          af_wr_en,
   input  logic                          af_full,
   output logic [DATA_W-1:0]             wdf_data,
   output logic [MASK_W-1:0]             wdf_mask,
   output logic                          wdf_wr_en,
   input  logic                          wdf_full,
   input  logic                          rd_data_valid,
   output logic [N_PORTS-1:0]            rd_valid,
   output logic                          rd_err
);

   localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int TW = $clog2(TAG_DEPTH);
   localparam int CW = TW + 1;

   typedef enum logic [1:0] {IDLE, W0, W1, CMD} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic            is_rd_q, is_rd_d;
   logic [GW-1:0]   rr_q, rr_d;
   logic [TW-1:0]   tag_wr_q, tag_wr_d;
   logic [TW-1:0]   tag_rd_q, tag_rd_d;
   logic [CW-1:0]   tag_cnt_q, tag_cnt_d;
   logic            beat_q, beat_d;
   logic            rd_err_q, rd_err_d;
   logic [GW-1:0]   tag_mem_q [TAG_DEPTH];

   logic [N_PORTS-1:0] elig;
   logic               rr_found;
   logic [GW-1:0]      rr_idx;
   logic               p0_ok;
   logic               win_valid;
   logic [GW-1:0]      win_idx;
   logic               tag_push;
   logic               tag_pop;
   logic               rd_hit;
   logic [GW-1:0]      tag_head;
   int                 k;

`ifdef ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_q, starve_d;
   logic          others_elig;
`endif

   // A read may only be granted while a tag slot is free; writes never need one.
   always_comb begin
      for (int i = 0; i < N_PORTS; i++)
         elig[i] = req_valid[i] & (~req_rnw[i] | (tag_cnt_q < CW'(TAG_DEPTH)));
   end

   // Round-robin search over ports 1..N_PORTS-1 starting at the pointer.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      k        = 0;
      for (int j = 0; j < N_PORTS - 1; j++) begin
         k = ((int'(rr_q) - 1 + j) % (N_PORTS - 1)) + 1;
         if (!rr_found && elig[k]) begin
            rr_found = 1'b1;
            rr_idx   = GW'(k);
         end
      end
   end

`ifdef ARB_STARVE_GUARD_EN
   assign others_elig = |elig[N_PORTS-1:1];
   assign p0_ok = elig[0] & ~((starve_q == SW'(STARVE_LIMIT)) & others_elig);
`else
   assign p0_ok = elig[0];
`endif

   assign win_valid = p0_ok | rr_found;
   assign win_idx   = p0_ok ? '0 : rr_idx;

   // Arbitration FSM and MIG push decode.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      is_rd_d   = is_rd_q;
      rr_d      = rr_q;
      tag_push  = 1'b0;
      req_ready = '0;
      af_addr   = '0;
      af_cmd    = 3'b000;
      af_wr_en  = 1'b0;
      wdf_data  = '0;
      wdf_mask  = '0;
      wdf_wr_en = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_d  = starve_q;
`endif
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               grant_d = win_idx;
               is_rd_d = req_rnw[win_idx];
               state_d = req_rnw[win_idx] ? CMD : W0;
               if (win_idx != '0)
                  rr_d = (win_idx == GW'(N_PORTS - 1)) ? GW'(1) : win_idx + GW'(1);
`ifdef ARB_STARVE_GUARD_EN
               if (win_idx != '0)
                  starve_d = '0;
               else if (others_elig && (starve_q < SW'(STARVE_LIMIT)))
                  starve_d = starve_q + SW'(1);
`endif
            end
         end
         W0: begin
            if (!wdf_full) begin
               wdf_wr_en = 1'b1;
               wdf_data  = req_wdata[int'(grant_q)*2*DATA_W +: DATA_W];
               wdf_mask  = req_wmask[int'(grant_q)*2*MASK_W +: MASK_W];
               state_d   = W1;
            end
         end
         W1: begin
            if (!wdf_full) begin
               wdf_wr_en = 1'b1;
               wdf_data  = req_wdata[int'(grant_q)*2*DATA_W + DATA_W +: DATA_W];
               wdf_mask  = req_wmask[int'(grant_q)*2*MASK_W + MASK_W +: MASK_W];
               state_d   = CMD;
            end
         end
         default: begin
            if (!af_full) begin
               af_wr_en           = 1'b1;
               af_addr            = req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
               af_cmd             = {2'b00, is_rd_q};
               req_ready[grant_q] = 1'b1;
               tag_push           = is_rd_q;
               state_d            = IDLE;
            end
         end
      endcase
   end

   // Read return: the head tag owns every beat until its second beat pops it.
   always_comb begin
      tag_head = tag_mem_q[tag_rd_q];
      rd_hit   = rd_data_valid & (tag_cnt_q != '0);
      tag_pop  = rd_hit & beat_q;
      beat_d   = rd_hit ? ~beat_q : beat_q;
      rd_err_d = rd_err_q | (rd_data_valid & (tag_cnt_q == '0));
      tag_wr_d = tag_wr_q + TW'(tag_push);
      tag_rd_d = tag_rd_q + TW'(tag_pop);
      tag_cnt_d = tag_cnt_q + CW'(tag_push) - CW'(tag_pop);
      for (int i = 0; i < N_PORTS; i++)
         rd_valid[i] = rd_hit & (tag_head == GW'(i));
   end

   assign rd_err = rd_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         is_rd_q   <= 1'b0;
         rr_q      <= GW'(1);
         tag_wr_q  <= '0;
         tag_rd_q  <= '0;
         tag_cnt_q <= '0;
         beat_q    <= 1'b0;
         rd_err_q  <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
         starve_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         is_rd_q   <= is_rd_d;
         rr_q      <= rr_d;
         tag_wr_q  <= tag_wr_d;
         tag_rd_q  <= tag_rd_d;
         tag_cnt_q <= tag_cnt_d;
         beat_q    <= beat_d;
         rd_err_q  <= rd_err_d;
`ifdef ARB_STARVE_GUARD_EN
         starve_q  <= starve_d;
`endif
      end
   end

   // Tag storage holds data only; validity comes from the reset pointers.
   always_ff @(posedge clk) begin
      if (tag_push)
         tag_mem_q[tag_wr_q] <= grant_q;
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
`timescale 1ns/1ps
module tb_mem_req_arbiter;

   localparam int N  = 4;
   localparam int AW = 31;
   localparam int DW = 128;
   localparam int MW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_rnw = '0;
   logic [N*AW-1:0]   req_addr = '0;
   logic [N*2*DW-1:0] req_wdata = '0;
   logic [N*2*MW-1:0] req_wmask = '0;
   logic [N-1:0]      req_ready;
   logic [AW-1:0]     af_addr;
   logic [2:0]        af_cmd;
   logic              af_wr_en;
   logic              af_full = 1'b0;
   logic [DW-1:0]     wdf_data;
   logic [MW-1:0]     wdf_mask;
   logic              wdf_wr_en;
   logic              wdf_full = 1'b0;
   logic              rd_data_valid = 1'b0;
   logic [N-1:0]      rd_valid;
   logic              rd_err;

   mem_req_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_rnw(req_rnw), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
      .af_addr(af_addr), .af_cmd(af_cmd), .af_wr_en(af_wr_en), .af_full(af_full),
      .wdf_data(wdf_data), .wdf_mask(wdf_mask), .wdf_wr_en(wdf_wr_en), .wdf_full(wdf_full),
      .rd_data_valid(rd_data_valid), .rd_valid(rd_valid), .rd_err(rd_err)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [2:0]    cmd;
      logic [N-1:0]  rdy;
   } af_t;
   typedef struct {
      logic [DW-1:0] data;
      logic [MW-1:0] mask;
   } wdf_t;

   af_t          af_q[$];
   wdf_t         wdf_q[$];
   logic [N-1:0] rd_q[$];

   int tests = 0;
   int fails = 0;
   int pend[N];
   logic [N-1:0] rdy_last = '0;
   logic af_full_nx = 1'b0;
   logic wdf_full_nx = 1'b0;
   logic rd_dv_nx = 1'b0;

   function automatic logic [AW-1:0] port_addr(input int p);
      case (p)
         0: return 31'h0A00;
         1: return 31'h0B00;
         2: return 31'h0100;
         default: return 31'h0C40;
      endcase
   endfunction

   function automatic logic [DW-1:0] beat_data(input int p, input int b);
      return {32'hDA7A0000 + 32'(p*16 + b), 32'h0, 32'h12345678, 32'hCAFE0000 + 32'(p)};
   endfunction

   function automatic logic [MW-1:0] beat_mask(input int p, input int b);
      return 16'h0F00 ^ 16'(p*16 + b);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_af(input int p, input logic rd);
      af_t e;
      e.addr = port_addr(p);
      e.cmd  = {2'b00, rd};
      e.rdy  = '0;
      e.rdy[p] = 1'b1;
      af_q.push_back(e);
   endtask

   task automatic push_wdf(input int p);
      wdf_t e;
      for (int b = 0; b < 2; b++) begin
         e.data = beat_data(p, b);
         e.mask = beat_mask(p, b);
         wdf_q.push_back(e);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int p);
      logic [N-1:0] v;
      v = '0;
      v[p] = 1'b1;
      return v;
   endfunction

   // One clock: inputs change just after the rising edge, we return at the
   // falling edge where outputs of that cycle are stable.
   task automatic step();
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) begin
         if (rdy_last[p] && pend[p] > 0) pend[p] = pend[p] - 1;
         req_valid[p] = (pend[p] > 0);
      end
      af_full = af_full_nx;
      wdf_full = wdf_full_nx;
      rd_data_valid = rd_dv_nx;
      @(negedge clk);
      rdy_last = req_ready;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while ((pend[0] + pend[1] + pend[2] + pend[3]) != 0 && k < budget) begin
         step();
         k++;
      end
      if ((pend[0] + pend[1] + pend[2] + pend[3]) != 0) begin
         tests++;
         fails++;
         $display("FAIL wait_done: pending requests %0d after %0d cycles, expected 0",
                  pend[0] + pend[1] + pend[2] + pend[3], budget);
      end
      step();
      step();
   endtask

   task automatic beats(input logic [N-1:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         rd_q.push_back(exp);
         rd_dv_nx = 1'b1;
         step();
      end
      rd_dv_nx = 1'b0;
   endtask

   // Monitor: pops expected transactions whenever the DUT pushes or a beat returns.
   always @(negedge clk) begin
      if (rst_n) begin
         if (af_wr_en) begin
            if (af_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL af_push: unexpected push addr %0h cmd %0h ready %0h, expected none",
                        af_addr, af_cmd, req_ready);
            end else begin
               af_t e;
               e = af_q.pop_front();
               check("af_addr", 128'(af_addr), 128'(e.addr));
               check("af_cmd", 128'(af_cmd), 128'(e.cmd));
               check("req_ready", 128'(req_ready), 128'(e.rdy));
            end
         end
         if (wdf_wr_en) begin
            if (wdf_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL wdf_push: unexpected push data %0h, expected none", wdf_data);
            end else begin
               wdf_t w;
               w = wdf_q.pop_front();
               check("wdf_data", 128'(wdf_data), 128'(w.data));
               check("wdf_mask", 128'(wdf_mask), 128'(w.mask));
            end
         end
         if (rd_data_valid) begin
            if (rd_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rd_beat: unexpected beat rd_valid %0h, expected none", rd_valid);
            end else begin
               logic [N-1:0] r;
               r = rd_q.pop_front();
               check("rd_valid", 128'(rd_valid), 128'(r));
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int p = 0; p < N; p++) begin
         pend[p] = 0;
         req_addr[p*AW +: AW] = port_addr(p);
         req_wdata[p*2*DW +: DW] = beat_data(p, 0);
         req_wdata[p*2*DW + DW +: DW] = beat_data(p, 1);
         req_wmask[p*2*MW +: MW] = beat_mask(p, 0);
         req_wmask[p*2*MW + MW +: MW] = beat_mask(p, 1);
      end

      // Reset state
      step(); step(); step();
      rst_n = 1'b1;
      step();
      check("rst_af_wr_en", 128'(af_wr_en), 128'(0));
      check("rst_wdf_wr_en", 128'(wdf_wr_en), 128'(0));
      check("rst_req_ready", 128'(req_ready), 128'(0));
      check("rst_rd_valid", 128'(rd_valid), 128'(0));
      check("rst_rd_err", 128'(rd_err), 128'(0));
      check("rst_af_cmd", 128'(af_cmd), 128'(0));

      // Round robin 1,2,3,1,2,3 from the reset pointer
      req_rnw = 4'b1110;
      for (int r = 0; r < 2; r++)
         for (int p = 1; p < 4; p++) push_af(p, 1'b1);
      pend[1] = 2; pend[2] = 2; pend[3] = 2;
      wait_done(40);
      for (int r = 0; r < 2; r++)
         for (int p = 1; p < 4; p++) beats(onehot(p), 2);
      step();

      // Port 0 arrives mid-stream and wins the next idle slot
      push_af(1, 1'b1); push_af(0, 1'b1);
      push_af(2, 1'b1); push_af(3, 1'b1);
      push_af(1, 1'b1); push_af(2, 1'b1); push_af(3, 1'b1);
      req_rnw = 4'b1111;
      pend[1] = 2; pend[2] = 2; pend[3] = 2;
      step();
      pend[0] = 1;
      wait_done(40);
      beats(4'b0010, 2); beats(4'b0001, 2); beats(4'b0100, 2); beats(4'b1000, 2);
      beats(4'b0010, 2); beats(4'b0100, 2); beats(4'b1000, 2);
      step();

      // Single read on port 2, command one cycle after valid
      push_af(2, 1'b1);
      pend[2] = 1;
      step();
      check("t1_cycle0_af_wr_en", 128'(af_wr_en), 128'(0));
      step();
      check("t1_cycle1_af_wr_en", 128'(af_wr_en), 128'(1));
      check("t1_cycle1_req_ready", 128'(req_ready), 128'(4'b0100));
      wait_done(10);
      beats(4'b0100, 2);
      step();

      // Stray beat with nothing outstanding: no steering, sticky error
      beats(4'b0000, 1);
      step();
      check("rd_err_set", 128'(rd_err), 128'(1));
      for (int i = 0; i < 5; i++) step();
      check("rd_err_sticky", 128'(rd_err), 128'(1));

      // Write on port 1 with the write-data FIFO full for three cycles
      req_rnw[1] = 1'b0;
      push_wdf(1);
      push_af(1, 1'b0);
      wdf_full_nx = 1'b1;
      pend[1] = 1;
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2_no_push_while_full", 128'(wdf_wr_en), 128'(0));
      end
      wdf_full_nx = 1'b0;
      step();
      check("t2_beat0_push", 128'(wdf_wr_en), 128'(1));
      step();
      check("t2_beat1_push", 128'(wdf_wr_en), 128'(1));
      check("t2_no_cmd_before_data", 128'(af_wr_en), 128'(0));
      step();
      check("t2_cmd_after_data", 128'(af_wr_en), 128'(1));
      wait_done(10);

      // Eight outstanding reads fill the tag FIFO; a write still gets through
      req_rnw[1] = 1'b1;
      for (int i = 0; i < 8; i++) push_af(1, 1'b1);
      pend[1] = 8;
      wait_done(40);
      req_rnw[2] = 1'b1;
      req_rnw[3] = 1'b0;
      push_wdf(3);
      push_af(3, 1'b0);
      push_af(2, 1'b1);
      pend[2] = 1; pend[3] = 1;
      for (int i = 0; i < 10; i++) step();
      check("t4_read_blocked", 128'(pend[2]), 128'(1));
      check("t4_write_granted", 128'(pend[3]), 128'(0));
      beats(4'b0010, 1);
      step(); step(); step();
      check("t4_still_blocked_mid_burst", 128'(pend[2]), 128'(1));
      beats(4'b0010, 1);
      wait_done(10);
      check("t4_read_resumed", 128'(pend[2]), 128'(0));
      beats(4'b0010, 14);
      beats(4'b0100, 2);
      step();

`ifdef ARB_STARVE_GUARD_EN
      // Starvation guard: 0,0,0,0,1,0
      req_rnw[0] = 1'b1;
      req_rnw[1] = 1'b1;
      for (int i = 0; i < 4; i++) push_af(0, 1'b1);
      push_af(1, 1'b1);
      push_af(0, 1'b1);
      pend[0] = 5; pend[1] = 1;
      wait_done(40);
      beats(4'b0001, 8);
      beats(4'b0010, 2);
      beats(4'b0001, 2);
      step();
`endif

      // Reset asserted while in W1 clears everything asynchronously
      req_rnw[0] = 1'b0;
      push_wdf(0);
      pend[0] = 1;
      step();
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_af_wr_en", 128'(af_wr_en), 128'(0));
      check("arst_wdf_wr_en", 128'(wdf_wr_en), 128'(0));
      check("arst_wdf_data", 128'(wdf_data), 128'(0));
      check("arst_req_ready", 128'(req_ready), 128'(0));
      check("arst_rd_err", 128'(rd_err), 128'(0));
      check("arst_rd_valid", 128'(rd_valid), 128'(0));
      pend[0] = 0;
      rdy_last = '0;
      step();
      rst_n = 1'b1;
      step(); step();
      check("post_rst_af_wr_en", 128'(af_wr_en), 128'(0));
      check("post_rst_wdf_wr_en", 128'(wdf_wr_en), 128'(0));
      check("post_rst_rd_err", 128'(rd_err), 128'(0));

      check("af_queue_drained", 128'(af_q.size()), 128'(0));
      check("wdf_queue_drained", 128'(wdf_q.size()), 128'(0));
      check("rd_queue_drained", 128'(rd_q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
